// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] EBREAK_INSTR = 32'h0010_0073;
    localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory, decode and redirect signals of the fetch unit.
interface instr_fetch_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] addr_o;
    logic [DATA_WIDTH-1:0] instr_i;
    logic [DATA_WIDTH-1:0] instr_o;
    logic [DATA_WIDTH-1:0] pc_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  redirect_i;
    logic [DATA_WIDTH-1:0] redirect_pc_i;
    logic                  halted_o;
    logic [31:0]           fetch_count_o;

    modport master (
        output addr_o,
        input  instr_i,
        output instr_o,
        output pc_o,
        output valid_o,
        input  ready_i,
        input  redirect_i,
        input  redirect_pc_i,
        output halted_o,
        output fetch_count_o
    );

    modport slave (
        input  addr_o,
        output instr_i,
        input  instr_o,
        input  pc_o,
        input  valid_o,
        output ready_i,
        output redirect_i,
        output redirect_pc_i,
        input  halted_o,
        input  fetch_count_o
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} entries; flush wins over push/pop.
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [63:0]
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  T                         wdata,
    output T                         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    T               r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW:0]    r_count;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: PC register, run/halt FSM, push/redirect priority and fetch counter.
//   state  | meaning
//   RUN    | fetching one word per cycle while the buffer has room
//   HALTED | EBREAK enqueued; no fetching, buffer still drains
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);

    fetch_state_e          r_state;
    fetch_state_e          w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [31:0]           r_fetch_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_is_ebreak;
    logic [PW:0]           w_count;
    fetch_entry_t          w_wdata;
    fetch_entry_t          w_head;

    // A redirect discards the head even when decode is ready for it.
    assign w_pop       = (w_count != '0) & bus.ready_i & ~bus.redirect_i;
    assign w_push      = (r_state == RUN) & ~bus.redirect_i & (~w_full | w_pop);
    assign w_is_ebreak = (bus.instr_i == EBREAK_INSTR);
    assign w_wdata     = '{pc: r_pc, instr: bus.instr_i};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (bus.redirect_i),
        .wdata (w_wdata),
        .rdata (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_push && w_is_ebreak) w_state_nxt = HALTED;
            HALTED:  if (bus.redirect_i) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
        end else if (bus.redirect_i) begin
            r_pc <= bus.redirect_pc_i & ~DATA_WIDTH'(3);
        end else if (w_push) begin
            r_pc          <= r_pc + DATA_WIDTH'(4);
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign bus.addr_o        = r_pc;
    assign bus.instr_o       = w_head.instr;
    assign bus.pc_o          = w_head.pc;
    assign bus.valid_o       = ~w_empty;
    assign bus.halted_o      = (r_state == HALTED);
    assign bus.fetch_count_o = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit against a queue-based fetch model.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    instr_fetch_unit_if #(.DATA_WIDTH(32)) bus ();

    instr_fetch_unit #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    always_comb bus.instr_i = mem[bus.addr_o[7:2]];

    int n_checks = 0;
    int n_errors = 0;

    fetch_entry_t m_q[$];
    logic [31:0]  m_pc;
    logic [31:0]  m_count;
    bit           m_halted;
    bit           saw_ebreak;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc     = 32'h0;
        m_count  = 32'h0;
        m_halted = 1'b0;
    endtask

    // Applies one clock edge worth of fetch rules to the model.
    task automatic model_update();
        int           sz;
        bit           popped;
        fetch_entry_t e;
        sz     = m_q.size();
        popped = 1'b0;
        if (bus.redirect_i) begin
            m_q.delete();
            m_pc     = bus.redirect_pc_i & 32'hFFFF_FFFC;
            m_halted = 1'b0;
        end else begin
            if (sz > 0 && bus.ready_i) begin
                popped = 1'b1;
                void'(m_q.pop_front());
            end
            if (!m_halted && (sz < DEPTH || popped)) begin
                e.pc    = m_pc;
                e.instr = mem[m_pc[7:2]];
                m_q.push_back(e);
                m_pc    = m_pc + 32'd4;
                m_count = m_count + 32'd1;
                if (e.instr == EBREAK_INSTR) m_halted = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        check_val("valid", {31'b0, bus.valid_o}, {31'b0, m_q.size() != 0});
        if (m_q.size() != 0) begin
            check_val("head_pc", bus.pc_o, m_q[0].pc);
            check_val("head_instr", bus.instr_o, m_q[0].instr);
        end
        check_val("addr", bus.addr_o, m_pc);
        check_val("halted", {31'b0, bus.halted_o}, {31'b0, m_halted});
        check_val("fetch_count", bus.fetch_count_o, m_count);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        check_all();
        if (bus.valid_o && bus.pc_o == 32'h84 && bus.instr_o == EBREAK_INSTR) saw_ebreak = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = a;
        cycle();
        bus.redirect_i    = 1'b0;
    endtask

    initial begin
        logic [31:0] pick;
        for (int i = 0; i < 64; i++) mem[i] = NOP_INSTR | (32'(i) << 7);
        mem[0]  = 32'h0010_0093;
        mem[1]  = 32'h0020_0113;
        mem[12] = 32'h0040_0613;
        mem[33] = EBREAK_INSTR;

        bus.ready_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        saw_ebreak        = 1'b0;

        #12;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // streaming from reset
        bus.ready_i = 1'b1;
        cycle();
        check_val("stream_pc0", bus.pc_o, 32'h0);
        check_val("stream_in0", bus.instr_o, 32'h0010_0093);
        cycle();
        check_val("stream_pc1", bus.pc_o, 32'h4);
        check_val("stream_in1", bus.instr_o, 32'h0020_0113);
        check_val("stream_cnt", bus.fetch_count_o, 32'd2);
        repeat (4) cycle();

        // back-pressure until full, then drain with no gaps
        do_reset();
        bus.ready_i = 1'b0;
        repeat (4) cycle();
        check_val("full_addr", bus.addr_o, 32'h10);
        check_val("full_cnt", bus.fetch_count_o, 32'd4);
        repeat (2) cycle();
        check_val("full_addr_hold", bus.addr_o, 32'h10);
        bus.ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_val("drain_valid", {31'b0, bus.valid_o}, 32'd1);
            check_val("drain_pc", bus.pc_o, 32'(k * 4));
            cycle();
        end

        // redirect with three buffered entries
        do_reset();
        bus.ready_i = 1'b0;
        repeat (3) cycle();
        check_val("buf3_cnt", bus.fetch_count_o, 32'd3);
        bus.ready_i = 1'b1;
        redirect_to(32'h30);
        check_val("redir_valid", {31'b0, bus.valid_o}, 32'd0);
        cycle();
        check_val("redir_pc", bus.pc_o, 32'h30);
        check_val("redir_instr", bus.instr_o, 32'h0040_0613);

        // run into EBREAK at 0x84
        redirect_to(32'h0);
        saw_ebreak = 1'b0;
        repeat (40) cycle();
        check_val("ebreak_halt", {31'b0, bus.halted_o}, 32'd1);
        check_val("ebreak_addr", bus.addr_o, 32'h88);
        check_val("ebreak_drained", {31'b0, bus.valid_o}, 32'd0);
        check_val("ebreak_seen", {31'b0, saw_ebreak}, 32'd1);
        redirect_to(32'h0);
        check_val("resume_halt", {31'b0, bus.halted_o}, 32'd0);
        cycle();
        check_val("resume_pc", bus.pc_o, 32'h0);

        // misaligned target and address wrap
        redirect_to(32'h32);
        check_val("misalign_addr", bus.addr_o, 32'h30);
        cycle();
        check_val("misalign_pc", bus.pc_o, 32'h30);
        redirect_to(32'hFFFF_FFFC);
        check_val("wrap_addr0", bus.addr_o, 32'hFFFF_FFFC);
        cycle();
        check_val("wrap_addr1", bus.addr_o, 32'h0);
        check_val("wrap_pc", bus.pc_o, 32'hFFFF_FFFC);

        // asynchronous reset with a full, halted buffer
        bus.ready_i = 1'b0;
        redirect_to(32'h78);
        repeat (5) cycle();
        check_val("pre_rst_halt", {31'b0, bus.halted_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", {31'b0, bus.valid_o}, 32'd0);
        check_val("arst_halted", {31'b0, bus.halted_o}, 32'd0);
        check_val("arst_count", bus.fetch_count_o, 32'd0);
        check_val("arst_addr", bus.addr_o, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            bus.ready_i    = ($urandom_range(0, 9) < 7);
            bus.redirect_i = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 6))
                0:       pick = 32'h0;
                1:       pick = 32'h30;
                2:       pick = 32'h70;
                3:       pick = 32'h7A;
                4:       pick = 32'hFFFF_FFF8;
                5:       pick = 32'h32;
                default: pick = $urandom;
            endcase
            bus.redirect_pc_i = pick;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
